// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR widths, collector defaults and the collector FSM state type
package fir_pkg;
  localparam int FIR_DIN_W = 8;
  localparam int FIR_DOUT_W = 10;
  localparam int COL_OUT_W = 8;
  localparam int COL_SHIFT = 2;
  localparam int COL_WARMUP = 4;
  typedef enum logic {WARM, RUN} col_state_t;
endpackage

// File: rtl/fir_out_collector_if.sv
// fir_out_collector_if: FIR sample input plus buffered valid/ready output stream
interface fir_out_collector_if import fir_pkg::*; #(
  parameter int DIN_W = FIR_DOUT_W,
  parameter int OUT_W = COL_OUT_W
);
  logic in_valid;
  logic [DIN_W-1:0] din;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] dout;
  modport master (output in_valid, din, out_ready, input out_valid, dout);
  modport slave (input in_valid, din, out_ready, output out_valid, dout);
endinterface

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: extra-bit-pointer FIFO with a registered head; a pop frees room for a same-cycle push
module fir_sample_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic empty,
  output logic full,
  output logic [AW:0] fill
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, rptr_nx;
  logic wr, rd;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fill = wptr - rptr;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign rptr_nx = rptr + (AW+1)'(rd);
  // head tracks the entry rptr will point at after this edge; a push into an empty FIFO bypasses mem
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      head <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      head <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(wr);
      rptr <= rptr_nx;
      if (wr && rptr_nx == wptr) head <= wdata;
      else if (rptr_nx != wptr) head <= mem[rptr_nx[AW-1:0]];
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/fir_out_collector.sv
// fir_out_collector: drops FIR warm-up samples, decimates, rounds/saturates and buffers results
module fir_out_collector import fir_pkg::*; #(
  parameter int DIN_W = FIR_DOUT_W,
  parameter int OUT_W = COL_OUT_W,
  parameter int SHIFT = COL_SHIFT,
  parameter int WARMUP = COL_WARMUP,
  parameter int DECIM = 1,
  parameter int DEPTH = 8,
  localparam int FW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  fir_out_collector_if.slave bus,
  output logic [FW-1:0] fill,
  output logic overflow,
  output logic [15:0] drop_cnt
);
  localparam int WCW = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
  localparam int RND = SHIFT > 0 ? 2 ** (SHIFT - 1) : 0;
  localparam col_state_t RST_ST = WARMUP == 0 ? RUN : WARM;
  col_state_t state, state_nx;
  logic [WCW-1:0] warm_cnt, warm_nx;
  logic [3:0] phase, phase_nx;
  logic [DIN_W:0] r;
  logic [OUT_W-1:0] sat;
  logic keep, empty, full, drop;
  always_comb begin
    state_nx = state;
    warm_nx = warm_cnt;
    phase_nx = phase;
    if (bus.in_valid && state == WARM) begin
      warm_nx = warm_cnt + 1'b1;
      state_nx = warm_cnt == WCW'(WARMUP - 1) ? RUN : WARM;
    end
    if (bus.in_valid && state == RUN) phase_nx = phase == 4'(DECIM - 1) ? '0 : phase + 1'b1;
  end
  assign keep = state == RUN && bus.in_valid && phase == '0;
  assign r = ({1'b0, bus.din} + (DIN_W+1)'(RND)) >> SHIFT;
  assign sat = r > (DIN_W+1)'(2 ** OUT_W - 1) ? '1 : r[OUT_W-1:0];
  assign drop = keep && full && !(bus.out_valid && bus.out_ready);
  assign bus.out_valid = !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RST_ST;
      warm_cnt <= '0;
      phase <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      state <= RST_ST;
      warm_cnt <= '0;
      phase <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      warm_cnt <= warm_nx;
      phase <= phase_nx;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + {15'd0, drop_cnt != 16'hffff};
      end
    end
  fir_sample_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .push(keep),
    .pop(bus.out_ready),
    .wdata(sat),
    .head(bus.dout),
    .empty(empty),
    .full(full),
    .fill(fill)
  );
endmodule

// File: tb/tb_fir_out_collector.sv
// tb_fir_out_collector: directed checks of warm-up, rounding, decimation, overflow, reset/clear and backpressure
module tb_fir_out_collector;
  import fir_pkg::*;
  logic clk = 1'b0;
  logic rst, clr_a;
  logic [3:0] fill_a, fill_b;
  logic ovf_a, ovf_b;
  logic [15:0] drops_a, drops_b;
  int checks = 0;
  int failures = 0;
  logic [7:0] got_a[$], got_b[$], exp_q[$];
  logic [9:0] t1 [8] = '{100, 101, 102, 103, 5, 6, 7, 1023};
  logic [7:0] t1e [4] = '{1, 2, 2, 255};
  logic [7:0] t2e [3] = '{1, 4, 7};
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] held;

  fir_out_collector_if ia ();
  fir_out_collector_if ib ();

  fir_out_collector dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .bus(ia.slave),
    .fill(fill_a), .overflow(ovf_a), .drop_cnt(drops_a)
  );
  fir_out_collector #(.WARMUP(0), .DECIM(3)) dut_b (
    .clk(clk), .rst(rst), .clr(1'b0), .bus(ib.slave),
    .fill(fill_b), .overflow(ovf_b), .drop_cnt(drops_b)
  );

  always #5 clk = ~clk;

  // record every accepted head as seen by the DUT just before the edge
  always @(posedge clk) begin
    if (ia.out_valid && ia.out_ready) got_a.push_back(ia.dout);
    if (ib.out_valid && ib.out_ready) got_b.push_back(ib.dout);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [9:0] v);
    ia.in_valid = 1'b1;
    ia.din = v;
    @(negedge clk);
    ia.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] v);
    ib.in_valid = 1'b1;
    ib.din = v;
    @(negedge clk);
    ib.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got_a.delete();
    got_b.delete();
  endtask

  task automatic warm_a();
    repeat (4) send_a(10'd0);
  endtask

  // leaves dut_a with fill=5, overflow=1, drop_cnt=1
  task automatic fill_overflow5();
    warm_a();
    ia.out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) send_a(10'(4 * k));
    ia.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    ia.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_a = 1'b0;
    ia.in_valid = 1'b0; ia.din = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.din = '0; ib.out_ready = 1'b1;
    #2;
    do_reset();
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_dout", ia.dout, 0);
    chk("rst_fill", fill_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_drops", drops_a, 0);

    for (int i = 0; i < 8; i++) begin
      send_a(t1[i]);
      if (i < 4) chk("t1_warm_valid", ia.out_valid, 0);
      else begin
        chk("t1_valid", ia.out_valid, 1);
        chk("t1_dout", ia.dout, t1e[i-4]);
      end
    end
    @(negedge clk);
    chk("t1_drained", ia.out_valid, 0);
    chk("t1_count", got_a.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_seq", got_a[i], t1e[i]);

    for (int i = 0; i < 7; i++) begin
      send_b(10'(4 * (i + 1)));
      if (i == 0) chk("t2_first", ib.dout, 1);
      if (i % 2 == 1) @(negedge clk);
    end
    @(negedge clk);
    chk("t2_count", got_b.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_seq", got_b[i], t2e[i]);

    do_reset();
    warm_a();
    ia.out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) send_a(10'(4 * k));
    chk("t3_fill", fill_a, 8);
    chk("t3_ovf", ovf_a, 1);
    chk("t3_drops", drops_a, 2);
    chk("t3_head", ia.dout, 1);
    ia.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_count", got_a.size(), 8);
    for (int k = 0; k < 8; k++) chk("t3_seq", got_a[k], k + 1);
    chk("t3_empty", fill_a, 0);
    chk("t3_ovf_sticky", ovf_a, 1);

    do_reset();
    warm_a();
    ia.out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) send_a(10'(4 * k));
    chk("t4_full", fill_a, 8);
    ia.out_ready = 1'b1;
    send_a(10'd36);
    chk("t4_fill_pp", fill_a, 8);
    chk("t4_ovf", ovf_a, 0);
    chk("t4_drops", drops_a, 0);
    repeat (9) @(negedge clk);
    chk("t4_count", got_a.size(), 9);
    chk("t4_first", got_a[0], 1);
    chk("t4_last", got_a[8], 9);

    do_reset();
    fill_overflow5();
    chk("t5_fill", fill_a, 5);
    chk("t5_ovf", ovf_a, 1);
    chk("t5_drops", drops_a, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_valid", ia.out_valid, 0);
    chk("t5_async_fill", fill_a, 0);
    chk("t5_async_ovf", ovf_a, 0);
    chk("t5_async_drops", drops_a, 0);
    chk("t5_async_dout", ia.dout, 0);
    @(negedge clk);
    rst = 1'b1;
    ia.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_a(10'd40);
      chk("t5_rewarm", ia.out_valid, 0);
    end
    send_a(10'd40);
    chk("t5_kept_valid", ia.out_valid, 1);
    chk("t5_kept_dout", ia.dout, 10);

    do_reset();
    fill_overflow5();
    clr_a = 1'b1;
    ia.in_valid = 1'b1;
    ia.din = 10'd40;
    #1;
    chk("t5c_pre_fill", fill_a, 5);
    @(negedge clk);
    clr_a = 1'b0;
    ia.in_valid = 1'b0;
    chk("t5c_valid", ia.out_valid, 0);
    chk("t5c_fill", fill_a, 0);
    chk("t5c_ovf", ovf_a, 0);
    chk("t5c_drops", drops_a, 0);
    ia.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_a(10'd44);
      chk("t5c_rewarm", ia.out_valid, 0);
    end
    send_a(10'd44);
    chk("t5c_kept_dout", ia.dout, 11);

    do_reset();
    warm_a();
    ia.out_ready = 1'b0;
    exp_q.delete();
    for (int k = 1; k <= 8; k++) begin
      send_a(10'(4 * k + 1));
      exp_q.push_back(8'(k));
    end
    for (int i = 0; i < 16; i++) begin
      ia.out_ready = pat[i % 4];
      held = ia.dout;
      @(negedge clk);
      if (!ia.out_ready) chk("t6_hold", ia.dout, held);
    end
    chk("t6_count", got_a.size(), exp_q.size());
    for (int k = 0; k < 8; k++) chk("t6_seq", got_a[k], exp_q[k]);
    chk("t6_empty", ia.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
